// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with run-time modulus (0..limit), parallel load,
// count enable and wrap/saturate boundary behaviour with registered ovf/unf pulses.
module updown_counter_mod #(
    parameter int WIDTH     = 8,
    parameter int SATURATE  = 0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ud,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             unf,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] RESET_VAL_W = WIDTH'(RESET_VAL);
    localparam logic             SAT_MODE    = (SATURATE != 0);

    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Flags default low so they last exactly one cycle after the offending step.
    always_comb begin
        out_d = out_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (load) begin
            out_d = (load_val > limit) ? limit : load_val;
        end else if (en) begin
            if (!ud) begin
                if (out_q < limit) begin
                    out_d = out_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                    out_d = SAT_MODE ? limit : '0;
                end
            end else begin
                if (out_q > limit) begin
                    // Count sits above a lowered limit: re-enter the range, not an underflow.
                    out_d = limit;
                end else if (out_q != '0) begin
                    out_d = out_q - 1'b1;
                end else begin
                    unf_d = 1'b1;
                    out_d = SAT_MODE ? '0 : limit;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= RESET_VAL_W;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign out     = out_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign at_max  = (out_q >= limit);
    assign at_zero = (out_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: a wrap-mode and a saturate-mode instance share stimulus
// and are checked every cycle against an arithmetic model, plus directed literal checks.
module tb_updown_counter_mod;

    logic       clk;
    logic       reset;
    logic       en;
    logic       ud;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] limit;

    logic [7:0] out_w, out_s;
    logic       ovf_w, ovf_s, unf_w, unf_s;
    logic       at_max_w, at_max_s, at_zero_w, at_zero_s;

    int vectors;
    int miscompares;
    bit chk_on;

    int m_out[2];
    int m_ovf[2];
    int m_unf[2];

    updown_counter_mod #(.WIDTH(8), .SATURATE(0), .RESET_VAL(5)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .ud(ud), .load(load),
        .load_val(load_val), .limit(limit), .out(out_w), .ovf(ovf_w),
        .unf(unf_w), .at_max(at_max_w), .at_zero(at_zero_w)
    );

    updown_counter_mod #(.WIDTH(8), .SATURATE(1), .RESET_VAL(5)) u_sat (
        .clk(clk), .reset(reset), .en(en), .ud(ud), .load(load),
        .load_val(load_val), .limit(limit), .out(out_s), .ovf(ovf_s),
        .unf(unf_s), .at_max(at_max_s), .at_zero(at_zero_s)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 = wrap mode, 1 = saturate mode
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int lim;
            lim = int'(limit);
            if (reset) begin
                m_out[i] = 5; m_ovf[i] = 0; m_unf[i] = 0;
            end else if (load) begin
                m_out[i] = (int'(load_val) > lim) ? lim : int'(load_val);
                m_ovf[i] = 0; m_unf[i] = 0;
            end else if (en && !ud) begin
                m_unf[i] = 0;
                if (m_out[i] + 1 > lim) begin
                    m_ovf[i] = 1;
                    m_out[i] = (i == 1) ? lim : 0;
                end else begin
                    m_ovf[i] = 0;
                    m_out[i] = m_out[i] + 1;
                end
            end else if (en && ud) begin
                m_ovf[i] = 0;
                if (m_out[i] == 0) begin
                    m_unf[i] = 1;
                    m_out[i] = (i == 1) ? 0 : lim;
                end else begin
                    m_unf[i] = 0;
                    m_out[i] = (m_out[i] > lim) ? lim : m_out[i] - 1;
                end
            end else begin
                m_ovf[i] = 0; m_unf[i] = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("wrap.out", 32'(out_w), 32'(m_out[0]));
            check("wrap.ovf", 32'(ovf_w), 32'(m_ovf[0]));
            check("wrap.unf", 32'(unf_w), 32'(m_unf[0]));
            check("wrap.at_max", 32'(at_max_w), 32'(m_out[0] >= int'(limit)));
            check("wrap.at_zero", 32'(at_zero_w), 32'(m_out[0] == 0));
            check("sat.out", 32'(out_s), 32'(m_out[1]));
            check("sat.ovf", 32'(ovf_s), 32'(m_ovf[1]));
            check("sat.unf", 32'(unf_s), 32'(m_unf[1]));
            check("sat.at_max", 32'(at_max_s), 32'(m_out[1] >= int'(limit)));
            check("sat.at_zero", 32'(at_zero_s), 32'(m_out[1] == 0));
        end
    end

    // Driver: apply one cycle of inputs, return 1 time unit after the edge
    task automatic apply(input logic r, input logic ld, input logic [7:0] lv,
                         input logic e, input logic u, input logic [7:0] lim);
        reset = r; load = ld; load_val = lv; en = e; ud = u; limit = lim;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_w[4];
        int exp_ovf[4];
        int exp_sat[3];
        vectors = 0; miscompares = 0; chk_on = 1'b0;
        reset = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; ud = 1'b0; limit = 8'd255;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;

        // Reset wins over load and en
        apply(0, 1, 8'd37, 0, 0, 8'd255);
        check("pre_reset.out", 32'(out_w), 32'd37);
        apply(1, 1, 8'd99, 1, 0, 8'd255);
        check("reset.out", 32'(out_w), 32'd5);
        check("reset.ovf", 32'(ovf_w), 32'd0);
        check("reset.unf", 32'(unf_w), 32'd0);
        check("reset.model", 32'(m_out[1]), 32'd5);

        // Wrap up
        exp_w = '{8, 9, 0, 1};
        exp_ovf = '{0, 0, 1, 0};
        apply(0, 1, 8'd7, 0, 0, 8'd9);
        for (int k = 0; k < 4; k++) begin
            apply(0, 0, 8'd0, 1, 0, 8'd9);
            check("wrap_up.out", 32'(out_w), 32'(exp_w[k]));
            check("wrap_up.ovf", 32'(ovf_w), 32'(exp_ovf[k]));
            check("wrap_up.at_max", 32'(at_max_w), 32'(exp_w[k] == 9));
            check("wrap_up.model", 32'(m_out[0]), 32'(exp_w[k]));
        end

        // Wrap down
        exp_w = '{0, 9, 8, 0};
        apply(0, 1, 8'd1, 0, 0, 8'd9);
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, 8'd0, 1, 1, 8'd9);
            check("wrap_dn.out", 32'(out_w), 32'(exp_w[k]));
            check("wrap_dn.unf", 32'(unf_w), 32'(k == 1));
            check("wrap_dn.at_zero", 32'(at_zero_w), 32'(k == 0));
        end

        // Saturate at the top, then at zero
        exp_sat = '{0, 1, 1};
        apply(0, 1, 8'd199, 0, 0, 8'd200);
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, 8'd0, 1, 0, 8'd200);
            check("sat_up.out", 32'(out_s), 32'd200);
            check("sat_up.ovf", 32'(ovf_s), 32'(exp_sat[k]));
        end
        check("sat_up.wrap_out", 32'(out_w), 32'd1);
        apply(0, 1, 8'd0, 0, 0, 8'd200);
        for (int k = 0; k < 2; k++) begin
            apply(0, 0, 8'd0, 1, 1, 8'd200);
            check("sat_dn.out", 32'(out_s), 32'd0);
            check("sat_dn.unf", 32'(unf_s), 32'd1);
            check("sat_dn.model", 32'(m_out[1]), 32'd0);
        end

        // Load clamp and lowered limit
        apply(0, 1, 8'd80, 0, 0, 8'd50);
        check("clamp.out", 32'(out_w), 32'd50);
        apply(0, 1, 8'd40, 0, 0, 8'd50);
        apply(0, 0, 8'd0, 0, 0, 8'd20);
        check("lowlim.out", 32'(out_w), 32'd40);
        check("lowlim.at_max", 32'(at_max_w), 32'd1);
        apply(0, 0, 8'd0, 1, 1, 8'd20);
        check("reenter.out", 32'(out_w), 32'd20);
        check("reenter.unf", 32'(unf_w), 32'd0);
        apply(0, 1, 8'd40, 0, 0, 8'd50);
        apply(0, 0, 8'd0, 1, 0, 8'd20);
        check("above_up.out", 32'(out_w), 32'd0);
        check("above_up.ovf", 32'(ovf_w), 32'd1);
        check("above_up.sat_out", 32'(out_s), 32'd20);

        // Load beats en, then en gating
        apply(0, 1, 8'd3, 1, 0, 8'd100);
        check("collide.out", 32'(out_w), 32'd3);
        for (int k = 0; k < 5; k++) begin
            apply(0, 0, 8'd0, 0, k[0], 8'd100);
            check("hold.out", 32'(out_w), 32'd3);
            check("hold.flags", 32'({ovf_w, unf_w}), 32'd0);
        end

        // limit = 0
        apply(0, 0, 8'd0, 1, 0, 8'd0);
        apply(0, 0, 8'd0, 1, 0, 8'd0);
        check("lim0_up.out", 32'(out_w), 32'd0);
        check("lim0_up.ovf", 32'(ovf_w), 32'd1);
        apply(0, 0, 8'd0, 1, 1, 8'd0);
        check("lim0_dn.wrap", 32'({out_w, unf_w}), 32'd1);
        check("lim0_dn.sat", 32'({out_s, unf_s}), 32'd1);

        // Randomised run against the model
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] lim;
            case ($urandom_range(0, 3))
                0: lim = 8'($urandom_range(0, 3));
                1: lim = 8'($urandom_range(0, 20));
                2: lim = 8'd255;
                default: lim = 8'($urandom_range(0, 255));
            endcase
            apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), lim);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
